pmk_match_seq: RTL and testbench

Parametrised, registered successor to the team's flat pattern/mode decode logic. It compares an input word against N_CH independently programmed masked patterns. Each channel has a selectable compare mode and a consecutive-cycle hold filter. It reports per-channel hits, rising-edge pulses, and the lowest-index hit. It sits between the primary-input bus and downstream control, replacing one-shot combinational decodes with debounced, programmable ones.

---
 rtl/pmk_pkg.sv | 23 ++
 rtl/pmk_channel.sv | 92 +++++++++
 rtl/pmk_match_seq.sv | 56 +++++
 tb/tb_pmk_match_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pmk_pkg.sv
// Shared types and helpers for the pmk masked-pattern matcher.
// Mode and state encodings are common to the channel and top level.
package pmk_pkg;

  typedef enum logic [1:0] {
    EQ     = 2'b00,
    NEQ    = 2'b01,
    ALLSET = 2'b10,
    OFF    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    HIT   = 2'b10
  } state_e;

  // Index width: at least one bit, even for a single channel.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pmk_channel.sv
// One match channel: config registers, compare, hold counter, hit FSM and pulse.
// Latency: match 1 cycle after the (hold+1)th consecutive true compare; no backpressure.
module pmk_channel
  import pmk_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int HOLD_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  din,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_mode,
  input  logic [WIDTH-1:0]  cfg_pattern,
  input  logic [WIDTH-1:0]  cfg_mask,
  input  logic [HOLD_W-1:0] cfg_hold,
  output logic              match,
  output logic              hit_pulse
);

  mode_e             mode_q;
  logic [WIDTH-1:0]  pattern_q;
  logic [WIDTH-1:0]  mask_q;
  logic [HOLD_W-1:0] hold_q;

  state_e            state_q, state_n;
  logic [HOLD_W-1:0] cnt_q, cnt_n;
  logic              pulse_q, pulse_n;
  logic              cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= OFF;
      pattern_q <= '0;
      mask_q    <= '0;
      hold_q    <= '0;
    end else if (cfg_we) begin
      mode_q    <= mode_e'(cfg_mode);
      pattern_q <= cfg_pattern;
      mask_q    <= cfg_mask;
      hold_q    <= cfg_hold;
    end
  end

  always_comb begin
    cond = 1'b0;
    case (mode_q)
      EQ:      cond = ((din ^ pattern_q) & mask_q) == '0;
      NEQ:     cond = ((din ^ pattern_q) & mask_q) != '0;
      ALLSET:  cond = (din & mask_q) == mask_q;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      pulse_q <= pulse_n;
    end
  end

  // A config write wins over everything, including a frozen (en=0) channel.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    if (cfg_we) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (en) begin
      if (cond) begin
        cnt_n   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        state_n = (cnt_q >= hold_q) ? HIT : COUNT;
      end else begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    end
    pulse_n = (state_n == HIT) && (state_q != HIT);
  end

  always_comb begin
    match     = (state_q == HIT);
    hit_pulse = pulse_q;
  end

endmodule

// File: rtl/pmk_match_seq.sv
// N_CH programmable debounced masked-pattern matchers with lowest-index hit encoder.
// Latency: match/hit_pulse registered (hold+1 cycles); any_match/hit_idx combinational; no backpressure.
module pmk_match_seq
  import pmk_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int N_CH   = 4,
  parameter  int HOLD_W = 4,
  localparam int IW     = idx_w(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  din,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [WIDTH-1:0]  cfg_pattern,
  input  logic [WIDTH-1:0]  cfg_mask,
  input  logic [HOLD_W-1:0] cfg_hold,
  output logic [N_CH-1:0]   match,
  output logic [N_CH-1:0]   hit_pulse,
  output logic              any_match,
  output logic [IW-1:0]     hit_idx
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    // Out-of-range cfg_ch values select no channel.
    pmk_channel #(
      .WIDTH  (WIDTH),
      .HOLD_W (HOLD_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .din         (din),
      .cfg_we      (cfg_we && (int'(cfg_ch) == c)),
      .cfg_mode    (cfg_mode),
      .cfg_pattern (cfg_pattern),
      .cfg_mask    (cfg_mask),
      .cfg_hold    (cfg_hold),
      .match       (match[c]),
      .hit_pulse   (hit_pulse[c])
    );
  end

  assign any_match = |match;

  always_comb begin
    hit_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = IW'(i);
    end
  end

endmodule

// File: tb/tb_pmk_match_seq.sv
// Directed self-checking bench for pmk_match_seq; a second 3-channel instance
// exercises out-of-range cfg_ch, which a 2-bit port cannot express for 4 channels.
module tb_pmk_match_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] din;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_pattern;
  logic [15:0] cfg_mask;
  logic [3:0]  cfg_hold;
  logic [3:0]  match;
  logic [3:0]  hit_pulse;
  logic        any_match;
  logic [1:0]  hit_idx;

  logic        cfg_we3;
  logic [1:0]  cfg_ch3;
  logic [2:0]  match3;
  logic [2:0]  hit_pulse3;
  logic        any_match3;
  logic [1:0]  hit_idx3;

  int n_tests;
  int n_fail;

  always #5 clk = ~clk;

  pmk_match_seq #(.WIDTH(16), .N_CH(4), .HOLD_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_hold(cfg_hold),
    .match(match), .hit_pulse(hit_pulse), .any_match(any_match), .hit_idx(hit_idx)
  );

  pmk_match_seq #(.WIDTH(16), .N_CH(3), .HOLD_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_mode(cfg_mode),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_hold(cfg_hold),
    .match(match3), .hit_pulse(hit_pulse3), .any_match(any_match3), .hit_idx(hit_idx3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] mode, input logic [15:0] pat,
                     input logic [15:0] mask, input logic [3:0] hold);
    cfg_we      = 1'b1;
    cfg_ch      = ch;
    cfg_mode    = mode;
    cfg_pattern = pat;
    cfg_mask    = mask;
    cfg_hold    = hold;
    tick();
    cfg_we      = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    en = 1'b0; din = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0;
    cfg_pattern = '0; cfg_mask = '0; cfg_hold = '0; cfg_we3 = 1'b0; cfg_ch3 = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;

    // Reset held: outputs stay zero whatever din/en do.
    chk("rst_match", match, 4'h0);
    chk("rst_pulse", hit_pulse, 4'h0);
    chk("rst_any", any_match, 1'b0);
    chk("rst_idx", hit_idx, 2'd0);
    for (int i = 0; i < 4; i++) begin
      din = (i % 2 == 1) ? 16'hFFFF : 16'h0000;
      en  = 1'b1;
      tick();
      chk("rst_hold_match", match, 4'h0);
    end

    // Released with all channels OFF.
    rst_n = 1'b1;
    en    = 1'b1;
    din   = 16'hFFFF;
    repeat (3) tick();
    chk("off_match", match, 4'h0);
    chk("off_any", any_match, 1'b0);

    // EQ with hold 2: hit on the third matching sample.
    din = 16'h12A5;
    cfg(2'd0, 2'b00, 16'h00A5, 16'h00FF, 4'd2);
    tick();
    chk("eq_s1", match, 4'h0);
    tick();
    chk("eq_s2", match, 4'h0);
    tick();
    chk("eq_s3_match", match, 4'h1);
    chk("eq_s3_pulse", hit_pulse, 4'h1);
    chk("eq_s3_idx", hit_idx, 2'd0);
    chk("eq_s3_any", any_match, 1'b1);
    tick();
    chk("eq_s4_match", match, 4'h1);
    chk("eq_s4_pulse", hit_pulse, 4'h0);
    din = 16'h12A4;
    tick();
    chk("eq_drop", match, 4'h0);

    // ALLSET with hold 3 across an en=0 gap.
    din = 16'hFFFF;
    cfg(2'd1, 2'b10, 16'h0000, 16'h8001, 4'd3);
    tick();
    tick();
    chk("frz_pre", match, 4'h0);
    en  = 1'b0;
    din = 16'h0000;
    repeat (5) tick();
    chk("frz_hold", match, 4'h0);
    chk("frz_pulse", hit_pulse, 4'h0);
    en  = 1'b1;
    din = 16'hFFFF;
    tick();
    chk("frz_s3", match, 4'h0);
    tick();
    chk("frz_s4_match", match, 4'h2);
    chk("frz_s4_pulse", hit_pulse, 4'h2);
    chk("frz_s4_idx", hit_idx, 2'd1);

    // Two NEQ channels, staggered then simultaneous hits.
    din = 16'h0001;
    cfg(2'd2, 2'b01, 16'h0000, 16'hFFFF, 4'd0);
    cfg(2'd3, 2'b01, 16'h0000, 16'hFFFF, 4'd0);
    chk("pri_c2_match", match, 4'h4);
    chk("pri_c2_pulse", hit_pulse, 4'h4);
    tick();
    chk("pri_match", match, 4'hC);
    chk("pri_pulse", hit_pulse, 4'h8);
    chk("pri_idx", hit_idx, 2'd2);
    chk("pri_any", any_match, 1'b1);

    // Rewrite ch2 while it is hit.
    cfg(2'd2, 2'b01, 16'h0000, 16'hFFFF, 4'd0);
    chk("rw_match", match, 4'h8);
    chk("rw_pulse", hit_pulse, 4'h0);
    chk("rw_idx", hit_idx, 2'd3);
    tick();
    chk("rw_rehit", match, 4'hC);
    chk("rw_rehit_pulse", hit_pulse, 4'h4);
    chk("rw_rehit_idx", hit_idx, 2'd2);

    // Out-of-range channel select on the 3-channel instance is ignored.
    cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_mode = 2'b01;
    cfg_pattern = 16'h0000; cfg_mask = 16'hFFFF; cfg_hold = 4'd0;
    tick();
    cfg_we3 = 1'b0;
    tick();
    chk("oor_match3", match3, 3'h0);
    chk("oor_any3", any_match3, 1'b0);
    chk("oor_main", match, 4'hC);
    cfg_we3 = 1'b1; cfg_ch3 = 2'd2;
    tick();
    cfg_we3 = 1'b0;
    tick();
    chk("inr_match3", match3, 3'h4);
    chk("inr_idx3", hit_idx3, 2'd2);

    // Saturating hold 15 on ch0, then asynchronous reset on cycle 18.
    din = 16'h00A5;
    cfg(2'd0, 2'b00, 16'h00A5, 16'h00FF, 4'd15);
    for (int k = 1; k <= 20; k++) begin
      if (k == 18) begin
        #3 rst_n = 1'b0;
        #1;
        chk("arst_match", match, 4'h0);
        chk("arst_pulse", hit_pulse, 4'h0);
        chk("arst_any", any_match, 1'b0);
        chk("arst_idx", hit_idx, 2'd0);
        chk("arst_match3", match3, 3'h0);
        break;
      end
      tick();
      chk($sformatf("sat_k%0d", k), match[0], (k >= 16) ? 1'b1 : 1'b0);
      if (k == 16) chk("sat_pulse", hit_pulse[0], 1'b1);
      if (k == 17) chk("sat_pulse_off", hit_pulse[0], 1'b0);
    end

    // After reset every channel is OFF again.
    tick();
    rst_n = 1'b1;
    en    = 1'b1;
    din   = 16'h00A5;
    tick();
    tick();
    chk("post_rst_match", match, 4'h0);
    chk("post_rst_match3", match3, 3'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
